// File: rtl/mod5_pkg.sv
// Shared types and the mod-5 step function for the serial divisible-by-5 link.
// Used by mod5_serial_tx and mod5_rem_tracker.
package mod5_pkg;

  localparam int REM_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // (2*rem + bit_in) % 5 using a single compare/subtract; rem 5..7 cannot occur and fold to 0
  function automatic logic [REM_W-1:0] mod5_step(input logic [REM_W-1:0] rem,
                                                 input logic             bit_in);
    logic [REM_W:0] acc;
    acc = {rem, bit_in};
    if (rem > 3'd4) begin
      acc = '0;
    end else if (acc >= 4'd5) begin
      acc = acc - 4'd5;
    end
    return acc[REM_W-1:0];
  endfunction

endpackage

// File: rtl/mod5_rem_tracker.sv
// Running remainder mod 5 of an MSB-first bit stream.
// rem is the remainder of bits already consumed; rem_next includes the presented bit.
module mod5_rem_tracker
  import mod5_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem,
  output logic [REM_W-1:0] rem_next
);

  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_d;

  assign rem_next = mod5_step(rem_q, bit_in);
  assign rem      = rem_q;

  // A new frame loading in the same cycle as the previous LSB must start from zero
  always_comb begin
    rem_d = rem_q;
    if (clear) begin
      rem_d = '0;
    end else if (step) begin
      rem_d = rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/mod5_serial_tx.sv
// MSB-first serialiser with frame markers, done pulse and optional running mod-5 tracking.
// Define MOD5_CHECK_EN to build the remainder tracker, exp_div and word_rem.
module mod5_serial_tx
  import mod5_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             serial_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             exp_div,
  output logic             done,
  output logic [REM_W-1:0] word_rem
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_TOP = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             accept;
  logic             load;

  // Held low during reset so nothing looks accepted while rst_n is asserted
  assign in_ready = rst_n && ((state_q == IDLE) ||
                              ((GAP_CYCLES == 0) && (state_q == SHIFT) && (cnt_q == '0)));
  assign accept   = in_ready && in_valid;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        load = accept;
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_TOP;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      shreg_d = in_data;
      cnt_d   = CNT_TOP;
      state_d = SHIFT;
    end

    // Frame markers are registered from the next-state view so they line up with serial_out
    valid_d = (state_d == SHIFT);
    first_d = valid_d && (cnt_d == CNT_TOP);
    last_d  = valid_d && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Shifting in zeros keeps the MSB flop at 0 whenever no frame is on the wire
  assign serial_out = shreg_q[WIDTH-1];
  assign ser_valid  = valid_q;
  assign ser_first  = first_q;
  assign ser_last   = last_q;
  assign done       = done_q;

`ifdef MOD5_CHECK_EN
  logic [REM_W-1:0] rem_cur;
  logic [REM_W-1:0] rem_next;
  logic [REM_W-1:0] word_rem_q, word_rem_d;

  mod5_rem_tracker u_rem_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (load),
    .step     (valid_q),
    .bit_in   (shreg_q[WIDTH-1]),
    .rem      (rem_cur),
    .rem_next (rem_next)
  );

  // Combinational in the bit's own cycle so it matches a receiver flagging after that bit
  assign exp_div = valid_q && (mod5_step(rem_cur, shreg_q[WIDTH-1]) == '0);

  always_comb begin
    word_rem_d = word_rem_q;
    if (done_d) begin
      word_rem_d = rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_rem_q <= '0;
    end else begin
      word_rem_q <= word_rem_d;
    end
  end

  assign word_rem = word_rem_q;
`else
  assign exp_div  = 1'b0;
  assign word_rem = '0;
`endif

endmodule
